// File: rtl/mac_pkg.sv
// Shared widths and limits for the multiply-accumulate stage.
// Operands are 4-bit unsigned; the product feeding the accumulator is 8 bits.
package mac_pkg;
   localparam int OPND_W    = 4;
   localparam int PROD_W    = 8;
   localparam int ACC_W_DEF = 12;
   localparam int CNT_W_DEF = 8;

   localparam logic [ACC_W_DEF-1:0] ACC_MAX = '1;
   localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic [OPND_W-1:0] a;
      logic [OPND_W-1:0] b;
      logic              last;
   } s1_t;
endpackage

// File: rtl/mac_accumulator_mult.sv
// 4x4 unsigned combinational multiplier feeding the accumulator.
module mac_accumulator_mult
   import mac_pkg::*;
(
   output logic [PROD_W-1:0] p,
   input  logic [OPND_W-1:0] a,
   input  logic [OPND_W-1:0] b
);
   assign p = PROD_W'(a) * PROD_W'(b);
endmodule

// File: rtl/mac_accumulator.sv
// Registered operand stage, multiplier and saturating group accumulator with
// a held valid/ready result register.
module mac_accumulator
   import mac_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OPND_W-1:0] in_a,
   input  logic [OPND_W-1:0] in_b,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_ovf
);
   localparam logic [ACC_W-1:0] ACC_SAT = '1;
   localparam logic [CNT_W-1:0] CNT_SAT = '1;

   s1_t               s1;
   logic              s1_valid;
   logic [PROD_W-1:0] p;
   logic [ACC_W-1:0]  acc;
   logic [CNT_W-1:0]  cnt;
   logic              ovf;

   logic              advance;
   logic              adv_last;
   logic              in_fire;
   logic [ACC_W:0]    sum_w;
   logic              beat_ovf;
   logic [ACC_W-1:0]  sum_sat;
   logic [CNT_W-1:0]  cnt_inc;

   // Only a last pair blocked by an unaccepted result holds stage 1.
   assign advance  = s1_valid && !(s1.last && out_valid && !out_ready);
   assign adv_last = advance && s1.last;
   assign in_ready = !clear && (!s1_valid || advance);
   assign in_fire  = in_valid && in_ready;

   mac_accumulator_mult u_mult (
      .p (p),
      .a (s1.a),
      .b (s1.b)
   );

   // acc <= ACC_SAT and p <= 225, so one carry bit covers every overflow.
   assign sum_w    = {1'b0, acc} + (ACC_W+1)'(p);
   assign beat_ovf = sum_w[ACC_W];
   assign sum_sat  = beat_ovf ? ACC_SAT : sum_w[ACC_W-1:0];
   assign cnt_inc  = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1       <= '0;
      end else if (clear) begin
         s1_valid <= 1'b0;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
         s1       <= '{a: in_a, b: in_b, last: in_last};
      end else if (advance) begin
         s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (clear || adv_last) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (advance) begin
         acc <= sum_sat;
         cnt <= cnt_inc;
         ovf <= ovf | beat_ovf;
      end
   end

   // A flushed group never reaches the result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
      end else if (adv_last && !clear) begin
         out_valid <= 1'b1;
         out_sum   <= sum_sat;
         out_count <= cnt_inc;
         out_ovf   <= ovf | beat_ovf;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mac_accumulator.sv
// Directed, table-driven check of mac_accumulator with hand-computed sums.
module tb_mac_accumulator;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_a = '0;
   logic [3:0]  in_b = '0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [11:0] out_sum;
   logic [7:0]  out_count;
   logic        out_ovf;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mac_accumulator dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_count (out_count),
      .out_ovf   (out_ovf)
   );

   typedef struct {
      int n;
      int a[4];
      int b[4];
      int sum;
      int cnt;
      int ovf;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Present one pair; returns at posedge+1 of the accepting edge.
   task automatic send(input int a, input int b, input bit last);
      bit done = 0;
      in_valid = 1'b1;
      in_a     = 4'(a);
      in_b     = 4'(b);
      in_last  = last;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (in_ready) done = 1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!done) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: pair (%0d,%0d) not accepted in 20 cycles", a, b);
      end
   endtask

   // Called right after the last handshake with out_ready=1: checks 2-cycle latency and the result.
   task automatic expect_result(input string name, input int sum, input int cnt, input int ovf);
      @(negedge clk);
      chk({name, "_lat1_valid"}, out_valid, 0);
      @(negedge clk);
      chk({name, "_lat2_valid"}, out_valid, 1);
      chk({name, "_sum"}, out_sum, sum);
      chk({name, "_count"}, out_count, cnt);
      chk({name, "_ovf"}, out_ovf, ovf);
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input int n, input int a0, b0, a1, b1, a2, b2, a3, b3,
                               input int sum, cnt, ovf);
      vec_t v;
      v.n = n;
      v.a = '{a0, a1, a2, a3};
      v.b = '{b0, b1, b2, b3};
      v.sum = sum;
      v.cnt = cnt;
      v.ovf = ovf;
      return v;
   endfunction

   initial begin
      vecs[0] = mk(3, 3, 5, 15, 15, 2, 7, 0, 0, 254, 3, 0);
      vecs[1] = mk(1, 0, 9, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      vecs[2] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      vecs[3] = mk(4, 15, 15, 15, 15, 15, 15, 15, 15, 900, 4, 0);
      vecs[4] = mk(2, 8, 8, 9, 9, 0, 0, 0, 0, 145, 2, 0);

      // reset state
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_out_count", out_count, 0);
      chk("rst_out_ovf", out_ovf, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // table-driven groups
      for (int v = 0; v < 5; v++) begin
         for (int i = 0; i < vecs[v].n; i++)
            send(vecs[v].a[i], vecs[v].b[i], i == vecs[v].n - 1);
         expect_result($sformatf("vec%0d", v), vecs[v].sum, vecs[v].cnt, vecs[v].ovf);
      end

      // saturation over 19 x 225 = 4275, then ovf must not leak into the next group
      for (int i = 0; i < 19; i++) send(15, 15, i == 18);
      expect_result("sat19", 4095, 19, 1);
      send(1, 1, 1);
      expect_result("after_sat", 1, 1, 0);

      // backpressure: result A held while group B accumulates and its last pair stalls
      out_ready = 1'b0;
      send(3, 5, 0);
      send(15, 15, 0);
      send(2, 7, 1);
      @(negedge clk);
      @(negedge clk);
      chk("bp_a_valid", out_valid, 1);
      chk("bp_a_sum", out_sum, 254);
      @(posedge clk);
      #1;
      send(2, 2, 0);
      send(4, 4, 1);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("bp_stall_in_ready", in_ready, 0);
         chk("bp_hold_valid", out_valid, 1);
         chk("bp_hold_sum", out_sum, 254);
         chk("bp_hold_count", out_count, 3);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_a_accept_sum", out_sum, 254);
      @(negedge clk);
      chk("bp_b_valid", out_valid, 1);
      chk("bp_b_sum", out_sum, 20);
      chk("bp_b_count", out_count, 2);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("bp_drained", out_valid, 0);
      @(posedge clk);
      #1;

      // clear flushes a partial group and refuses a simultaneous input
      send(5, 5, 0);
      send(6, 6, 0);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_a     = 4'd9;
      in_b     = 4'd9;
      in_last  = 1'b1;
      @(negedge clk);
      chk("clr_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("clr_no_out", out_valid, 0);
      end
      @(posedge clk);
      #1;
      send(1, 2, 1);
      expect_result("clr", 2, 1, 0);

      // asynchronous reset mid-group with a result pending
      out_ready = 1'b0;
      send(9, 9, 1);
      @(negedge clk);
      @(negedge clk);
      chk("arst_pending", out_valid, 1);
      @(posedge clk);
      #1;
      send(3, 3, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_sum", out_sum, 0);
      chk("arst_count", out_count, 0);
      chk("arst_ovf", out_ovf, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      send(7, 3, 1);
      expect_result("arst_after", 21, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
